// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: emits the index of every set bit of an accepted vector, lowest first, one per handshake.
// Optional ENC_COUNT_EN adds out_count, the popcount of the accepted vector.
module seq_priority_encoder #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] in_vec,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
`ifdef ENC_COUNT_EN
  output logic [W:0]   out_count,
`endif
  output logic         none_pulse
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         none_q, none_d;
  logic [N-1:0] cleared;
  logic [W-1:0] low_idx;
  logic         accept;

  // Dropping the lowest set bit also tells us whether it was the only one.
  assign cleared = pending_q & (pending_q - ONE);

  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = i[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so in_ready reads 0 throughout reset.
        in_ready = enable && rst_n;
        accept   = in_valid && in_ready;
        if (accept) begin
          if (|in_vec) begin
            pending_d = in_vec;
            state_d   = EMIT;
          end else begin
            none_d = 1'b1;
          end
        end
      end
      EMIT: begin
        out_valid = enable;
        if (out_valid && out_ready) begin
          pending_d = cleared;
          if (cleared == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_code   = (state_q == EMIT) ? low_idx : '0;
  assign out_last   = (state_q == EMIT) && (cleared == '0);
  assign none_pulse = none_q;

`ifdef ENC_COUNT_EN
  logic [W:0] count_q, count_d;

  function automatic logic [W:0] popcount(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + {{W{1'b0}}, v[i]};
    return c;
  endfunction

  assign count_d = accept ? popcount(in_vec) : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed self-checking bench for seq_priority_encoder (N=16).
module tb_seq_priority_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] in_vec;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_code;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        none_pulse;
`ifdef ENC_COUNT_EN
  logic [4:0]  out_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_priority_encoder #(.N(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_vec     (in_vec),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_code   (out_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
`ifdef ENC_COUNT_EN
    .out_count  (out_count),
`endif
    .none_pulse (none_pulse)
  );

  always #5 clk = ~clk;

  // Presents vec for exactly one rising edge; returns 1 ns after that edge.
  task automatic send(input logic [15:0] vec);
    @(posedge clk); #1;
    in_vec = vec; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_vec = 16'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; in_vec = 16'h0; in_valid = 1'b0; out_ready = 1'b1;
    #3;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_code !== 4'd0) $display("FAIL reset_out_code got %0d exp 0", out_code); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_last); else pass_cnt++;
    total_cnt++; if (none_pulse !== 1'b0) $display("FAIL reset_none got %b exp 0", none_pulse); else pass_cnt++;
`ifdef ENC_COUNT_EN
    total_cnt++; if (out_count !== 5'd0) $display("FAIL reset_count got %0d exp 0", out_count); else pass_cnt++;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got %b exp 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_single_lsb;
    send(16'h0001);
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL lsb_valid got %b exp 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_code !== 4'd0) $display("FAIL lsb_code got %0d exp 0", out_code); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b1) $display("FAIL lsb_last got %b exp 1", out_last); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL lsb_in_ready_emit got %b exp 0", in_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL lsb_in_ready_after got %b exp 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL lsb_valid_after got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_single_msb;
    send(16'h8000);
    @(negedge clk);
    total_cnt++; if (out_code !== 4'd15) $display("FAIL msb_code got %0d exp 15", out_code); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b1) $display("FAIL msb_last got %b exp 1", out_last); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL msb_valid_after got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_codes [4];
    exp_codes = '{4'd0, 4'd5, 4'd10, 4'd15};
    send(16'h8421);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b exp 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_code !== exp_codes[i]) $display("FAIL b2b_code[%0d] got %0d exp %0d", i, out_code, exp_codes[i]); else pass_cnt++;
      total_cnt++; if (out_last !== (i == 3)) $display("FAIL b2b_last[%0d] got %b exp %b", i, out_last, (i == 3)); else pass_cnt++;
`ifdef ENC_COUNT_EN
      total_cnt++; if (out_count !== 5'd4) $display("FAIL b2b_count[%0d] got %0d exp 4", i, out_count); else pass_cnt++;
`endif
    end
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_valid_end got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready_end got %b exp 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_all_ones_stall;
    int exp_idx = 0;
    int cyc = 0;
    send(16'hFFFF);
    out_ready = 1'b0;
    while (exp_idx < 16 && cyc < 64) begin
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL ones_valid[c%0d] got %b exp 1", cyc, out_valid); else pass_cnt++;
      total_cnt++; if (out_code !== exp_idx[3:0]) $display("FAIL ones_code[c%0d] got %0d exp %0d", cyc, out_code, exp_idx); else pass_cnt++;
      total_cnt++; if (out_last !== (exp_idx == 15)) $display("FAIL ones_last[c%0d] got %b exp %b", cyc, out_last, (exp_idx == 15)); else pass_cnt++;
      if (out_ready) exp_idx++;
      @(posedge clk); #1;
      out_ready = ~out_ready;
      cyc++;
    end
    total_cnt++; if (exp_idx !== 16) $display("FAIL ones_count got %0d exp 16", exp_idx); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ones_valid_end got %b exp 0", out_valid); else pass_cnt++;
    out_ready = 1'b1;
  endtask

  task automatic test_zero_vector;
    @(posedge clk); #1;
    in_vec = 16'h0; in_valid = 1'b1;
    @(negedge clk);
    total_cnt++; if (none_pulse !== 1'b0) $display("FAIL zero_none_before got %b exp 0", none_pulse); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (none_pulse !== 1'b1) $display("FAIL zero_none got %b exp 1", none_pulse); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL zero_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL zero_in_ready got %b exp 1", in_ready); else pass_cnt++;
`ifdef ENC_COUNT_EN
    total_cnt++; if (out_count !== 5'd0) $display("FAIL zero_count got %0d exp 0", out_count); else pass_cnt++;
`endif
    @(negedge clk);
    total_cnt++; if (none_pulse !== 1'b0) $display("FAIL zero_none_after got %b exp 0", none_pulse); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL zero_valid_after got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_enable_freeze;
    send(16'h0110);
    @(negedge clk);
    total_cnt++; if (out_code !== 4'd4) $display("FAIL en_first_code got %0d exp 4", out_code); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b0) $display("FAIL en_first_last got %b exp 0", out_last); else pass_cnt++;
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL en_off_valid[%0d] got %b exp 0", i, out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL en_off_in_ready[%0d] got %b exp 0", i, in_ready); else pass_cnt++;
      if (i < 2) @(posedge clk);
    end
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL en_resume_valid got %b exp 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_code !== 4'd8) $display("FAIL en_resume_code got %0d exp 8", out_code); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b1) $display("FAIL en_resume_last got %b exp 1", out_last); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL en_end_valid got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_emit;
    send(16'h00F0);
    @(negedge clk);
    total_cnt++; if (out_code !== 4'd4) $display("FAIL rst_first_code got %0d exp 4", out_code); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_code !== 4'd0) $display("FAIL rst_mid_code got %0d exp 0", out_code); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b0) $display("FAIL rst_mid_last got %b exp 0", out_last); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready got %b exp 0", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_after_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_after_in_ready got %b exp 1", in_ready); else pass_cnt++;
    send(16'h0002);
    @(negedge clk);
    total_cnt++; if (out_code !== 4'd1) $display("FAIL rst_new_code got %0d exp 1", out_code); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b1) $display("FAIL rst_new_last got %b exp 1", out_last); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_new_end_valid got %b exp 0", out_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single_lsb;
    test_single_msb;
    test_back_to_back;
    test_all_ones_stall;
    test_zero_vector;
    test_enable_freeze;
    test_reset_mid_emit;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
